// File: rtl/uart_bus_responder_pkg.sv
// Shared types and helpers for the bus UART responder.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_bus_responder_if.sv
// Host parallel-bus signals of the UART controller.
interface uart_bus_if;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       wrn;
  logic       rdn;
  logic       tbre;
  logic       tsre;
  logic       data_ready;
  logic       framing_error;
  logic       parity_error;

  modport master (
    output data_in, wrn, rdn,
    input  data_out, data_oe, tbre, tsre, data_ready, framing_error, parity_error
  );

  modport slave (
    input  data_in, wrn, rdn,
    output data_out, data_oe, tbre, tsre, data_ready, framing_error, parity_error
  );
endinterface

// File: rtl/uart_bus_responder_rx.sv
// Serial receiver: 2-FF synchroniser, start-bit glitch filter, bit-centre sampling.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_ferr,
  output logic       rx_perr
);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  logic          sync1_q, sync2_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shr_q, shr_d;
  logic          par_q, par_d;
  logic          bit_end;

  assign bit_end = (cnt_q == LAST);

  // State and datapath registers; synchroniser idles at line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shr_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shr_q   <= shr_d;
      par_q   <= par_d;
    end
  end

  // Next-state: the detecting cycle counts as the first cycle of the start
  // bit, which pulls the sample points back toward the true bit centres.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shr_d   = shr_q;
    par_d   = par_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) begin
          state_d = RX_START;
          cnt_d   = CW'(1);
        end
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_end) begin
        shr_d = {sync2_q, shr_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = PARITY_EN ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (bit_end) begin
        par_d   = sync2_q;
        state_d = RX_STOP;
      end
      RX_STOP: if (bit_end) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  // Outputs: completion pulse on the stop sample, with that frame's errors.
  always_comb begin
    rx_byte = shr_q;
    rx_done = (state_q == RX_STOP) && bit_end;
    rx_ferr = ~sync2_q;
    rx_perr = PARITY_EN && (par_q != even_parity(shr_q));
  end

endmodule

// File: rtl/uart_bus_responder.sv
// Parallel-bus UART responder: THR/TSR transmitter, bus strobes and status.
module uart_bus_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  uart_bus_if.slave  bus,
  output logic       txd,
  input  logic       rxd
);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          wrn_q, rdn_q;
  logic [7:0]    thr_q, thr_d, tsr_q, tsr_d, rbr_q, rbr_d;
  logic          thr_full_q, thr_full_d, tsre_q, tsre_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic          dr_q, dr_d, fe_q, fe_d, pe_q, pe_d;
  logic          wr_ev, rd_rel, load, tx_end;
  logic [7:0]    rx_byte;
  logic          rx_done, rx_ferr, rx_perr;

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT), .PARITY_EN(PARITY_EN)) u_rx (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rx_byte(rx_byte), .rx_done(rx_done), .rx_ferr(rx_ferr), .rx_perr(rx_perr)
  );

  assign wr_ev  = !wrn_q && bus.wrn;
  assign rd_rel = !rdn_q && bus.rdn;
  assign tx_end = (tx_cnt_q == LAST);

  // All registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrn_q      <= 1'b1;
      rdn_q      <= 1'b1;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      tsr_q      <= '0;
      tsre_q     <= 1'b1;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      rbr_q      <= '0;
      dr_q       <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      wrn_q      <= bus.wrn;
      rdn_q      <= bus.rdn;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      tsr_q      <= tsr_d;
      tsre_q     <= tsre_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      rbr_q      <= rbr_d;
      dr_q       <= dr_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
    end
  end

  // TX next-state; a load from STOP chains frames with no idle bit, and a
  // write on the load cycle leaves the new byte pending in THR.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_state_q == TX_IDLE || tx_end) ? '0 : tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tsr_d      = tsr_q;
    tsre_d     = tsre_q;
    load       = 1'b0;
    unique case (tx_state_q)
      TX_IDLE:   load = thr_full_q;
      TX_START:  if (tx_end) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
      end
      TX_DATA:   if (tx_end) begin
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'd7) tx_state_d = PARITY_EN ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_end) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_end) begin
        if (thr_full_q) load = 1'b1;
        else begin
          tsre_d     = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default:   tx_state_d = TX_IDLE;
    endcase
    if (load) begin
      tsr_d      = thr_q;
      tsre_d     = 1'b0;
      tx_state_d = TX_START;
    end
    thr_d      = wr_ev ? bus.data_in : thr_q;
    thr_full_d = wr_ev ? 1'b1 : (load ? 1'b0 : thr_full_q);
  end

  // Receive status; a completing frame beats a simultaneous read-release.
  always_comb begin
    rbr_d = rx_done ? rx_byte : rbr_q;
    dr_d  = rx_done ? 1'b1    : (rd_rel ? 1'b0 : dr_q);
    fe_d  = rx_done ? rx_ferr : (rd_rel ? 1'b0 : fe_q);
    pe_d  = rx_done ? rx_perr : (rd_rel ? 1'b0 : pe_q);
  end

  // Outputs: serial line level per TX state, and bus status.
  always_comb begin
    unique case (tx_state_q)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tsr_q[tx_idx_q];
      TX_PARITY: txd = even_parity(tsr_q);
      default:   txd = IDLE_LVL;
    endcase
    bus.data_out      = rbr_q;
    bus.data_oe       = ~bus.rdn;
    bus.tbre          = ~thr_full_q;
    bus.tsre          = tsre_q;
    bus.data_ready    = dr_q;
    bus.framing_error = fe_q;
    bus.parity_error  = pe_q;
  end

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
Device-side model of the board's parallel-bus UART controller. It answers the host's rdn/wrn strobes on the 8-bit shared data bus, serialises written bytes onto txd, and deserialises rxd into a receive buffer. It drives the tbre/tsre/data_ready/framing_error/parity_error status lines. It serves as a synthesizable UART for FPGA-only builds and as the bus-functional responder in host-side benches.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 4
PARITY_EN, 0, 1 = 8E1 framing (even parity), 0 = 8N1

Ports:
clk  in  1  system clock, same domain as host strobes
rst  in  1  synchronous reset, active-low
data_in  in  8  bus value written by host, valid while wrn low
data_out  out  8  receive buffer (RBR) contents
data_oe  out  1  bus drive enable; top level tristates shared bus with it
wrn  in  1  host write strobe, active-low
rdn  in  1  host read strobe, active-low
tbre  out  1  transmit holding register empty
tsre  out  1  transmit shift register empty (line idle)
data_ready  out  1  RBR holds unread byte
framing_error  out  1  last received frame had stop bit = 0
parity_error  out  1  last received frame failed even parity (0 if PARITY_EN=0)
txd  out  1  serial output, idle high
rxd  in  1  serial input, asynchronous

Behaviour:
- Reset (rst==0 at posedge):
  - txd=1, tbre=1, tsre=1, data_ready=0, framing_error=0, parity_error=0, data_out=0
  - TX and RX FSMs to IDLE
  - Reset mid-frame aborts the frame immediately; txd returns high on the next cycle.
- Strobe sampling: wrn_q/rdn_q are registered copies.
  - Write event: wrn_q==0 && wrn==1 (rising edge).
  - Read-release event: rdn_q==0 && rdn==1.
- Write:
  - On a write event, THR <= data_in and tbre <= 0 at that edge.
  - Write while tbre==0 overwrites THR (host protocol violation; no error flag).
- TX FSM states:
  - IDLE: if THR full, TSR <= THR, tbre <= 1, tsre <= 0, go to START. Load occurs 1 cycle after tbre falls.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT each; 3-bit index.
  - PARITY: only if PARITY_EN; txd = ^TSR.
  - STOP: txd=1 for CLKS_PER_BIT.
  - At STOP end: if THR full, reload and go to START directly (back-to-back, no idle gap, tsre stays 0); else tsre <= 1 and go to IDLE.
- Read:
  - data_oe = ~rdn (combinational), so the host samples a stable RBR on the edge after it drives rdn low.
  - data_ready, framing_error and parity_error clear on the read-release event.
- RX:
  - rxd passes through a 2-FF synchroniser.
  - IDLE: wait for synchronised 0.
  - START: at CLKS_PER_BIT/2 recheck; if 1, treat as glitch and return to IDLE.
  - DATA: sample at bit centres, 8 bits, then PARITY (if enabled), then STOP sample.
  - On the STOP sample:
    - RBR <= byte
    - data_ready <= 1
    - framing_error <= ~stop
    - parity_error <= PARITY_EN & (parity mismatch)
    - return to IDLE; a new start bit is accepted from the following cycle.
- Boundary cases:
  - Overrun (frame completes while data_ready==1): RBR overwritten, data_ready stays 1.
  - Frame completion in the same cycle as read-release: completion wins; data_ready=1 with the new byte.
  - Simultaneous write event and TX IDLE load: the old THR is loaded into TSR and the new data_in lands in THR; tbre=0.
  - Bit timer: counter width $clog2(CLKS_PER_BIT), wraps to 0 at CLKS_PER_BIT-1.

Decomposition:
- Package uart_pkg:
  - TX/RX state enums
  - localparams for data bits (8) and idle level (1)
  - function even_parity(byte)
- Sub-module uart_rx_deser: synchroniser, RX FSM, bit timer. Outputs byte, done pulse and error bits.
- TX FSM, THR and bus logic stay in uart_bus_responder.

Test Plan:
- Reset with rst=0 for 2 cycles -> txd=1, tbre=1, tsre=1, data_ready=0, data_oe=0 (rdn=1).
- CLKS_PER_BIT=4: wrn pulse low 1 cycle with data_in=8'hA5 -> tbre 0 then 1 one cycle later, tsre=0; txd waveform 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; tsre=1 after stop.
- Two writes 8'h41 and 8'h42, second issued while first is in DATA -> back-to-back frames, no idle bit between them, tsre stays 0 until second stop.
- Drive rxd frame 8'h3C with good stop -> data_ready=1, framing_error=0; rdn low -> data_out=8'h3C, data_oe=1; rdn high -> data_ready=0.
- rxd frame with stop bit 0 -> framing_error=1, data_ready=1; PARITY_EN=1 with wrong parity on 8'h01 -> parity_error=1.
- Two rxd frames 8'h11 then 8'h22 with no read -> data_out=8'h22, data_ready=1; rst=0 mid-TX frame -> txd=1 next cycle, tsre=1.
